ps2_command_decoder: RTL and testbench
======================================

PS2_COMMAND_DECODER -- requirements
Module: ps2_command_decoder

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: CLOCK_50 cycles PS2_CLK must hold a level before it is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: maximum idle time between PS/2 clock falling edges inside a frame.
REQ-003 SHALL have port CLOCK_50, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port PS2_CLK, input, 1 bit: keyboard clock, asynchronous to CLOCK_50.
REQ-006 SHALL have port PS2_DAT, input, 1 bit: keyboard data, asynchronous to CLOCK_50.
REQ-007 SHALL have port Direction, output, 4 bits: held arrow key, one-hot (UP=0001, DOWN=0010, LEFT=0100, RIGHT=1000), or 0000 when no arrow is held.
REQ-008 SHALL have port Command, output, 1 bit: high while Space is held.
REQ-009 SHALL have port play_en, output, 1 bit: playback enable, toggled by each Enter make code.
REQ-010 SHALL have port frame_error, output, 1 bit: one-cycle pulse on every discarded frame.

Function
REQ-011 SHALL pass PS2_CLK and PS2_DAT each through a 2-flop synchronizer.
REQ-012 SHALL change filtered PS2_CLK only after the synchronized value has differed from it for FILTER_LEN consecutive cycles.
REQ-013 SHALL sample synchronized PS2_DAT on each falling edge of filtered PS2_CLK.
REQ-014 SHALL frame 11 bits: start=0, 8 data bits LSB first, odd parity, stop=1.
REQ-015 SHALL assert byte_valid for 1 cycle, 1 cycle after the stop-bit edge, only if start, parity and stop are all correct.
REQ-016 SHALL otherwise discard the frame, pulse frame_error for 1 cycle, and return the bit counter to 0.
REQ-017 SHALL abort a partial frame (bit counter 1..10) that sees no falling edge for TIMEOUT_CYCLES cycles: clear the bit counter and pulse frame_error; the timeout counter saturates and is cleared on every edge.
REQ-018 SHALL implement a scan-code FSM with states IDLE, EXT, BRK, EXT_BRK, advanced only on byte_valid.
REQ-019 SHALL move IDLE to EXT on E0, IDLE to BRK on F0, and EXT to EXT_BRK on F0.
REQ-020 SHALL treat any other byte in IDLE as a make code, in EXT as an extended make, in BRK as a break, and in EXT_BRK as an extended break; each returns the FSM to IDLE.
REQ-021 SHALL on extended make set Direction, with the last arrow pressed winning: 75 to UP, 72 to DOWN, 6B to LEFT, 74 to RIGHT.
REQ-022 SHALL on extended break clear Direction only if the released arrow equals the currently held arrow; otherwise Direction is unchanged.
REQ-023 SHALL set Command on make 29 (Space) and clear it on break 29; typematic repeats of 29 leave Command high.
REQ-024 SHALL toggle play_en on make 5A (Enter), with typematic repeats suppressed by an enter_held flag that is cleared on break 5A.
REQ-025 SHALL ignore unlisted codes apart from the FSM state transitions they cause.
REQ-026 SHALL return the FSM to IDLE on frame_error; held outputs are unchanged.
REQ-027 SHALL update Direction, Command and play_en on the cycle after byte_valid (registered outputs, latency 1).

Reset
REQ-028 SHALL on Reset clear to 0 all of: Direction, Command, play_en, frame_error, the FSM (IDLE), the bit counter, the timeout counter, enter_held and both synchronizers; filtered PS2_CLK resets to 1.
REQ-029 SHALL treat Reset asserted mid-frame as a clean abort: the partial byte is lost, no frame_error pulse is produced, and reception resumes at the next start bit.

Structure
REQ-030 SHALL take the scan-code constants (E0, F0, 75, 72, 6B, 74, 29, 5A) and the direction one-hot encodings from a shared package also used by the grid display logic.
REQ-031 SHALL place the synchronizer, filter, framing and timeout logic in sub-module ps2_rx (outputs byte_valid, byte_data, frame_error); the scan-code FSM stays in the top module.

Verification
REQ-032 SHALL cover: frames E0,75 -> Direction=0001 one cycle after the second byte_valid; then E0,F0,75 -> Direction=0000.
REQ-033 SHALL cover: E0,6B then E0,74 then E0,F0,6B -> Direction is 0100, then 1000, and stays 1000.
REQ-034 SHALL cover: 5A, 5A, F0,5A, 5A -> play_en goes 0, 1, 1, 1, 0.
REQ-035 SHALL cover: byte 29 with a wrong parity bit -> frame_error pulses once and Command stays 0; a following good 29 -> Command=1.
REQ-036 SHALL cover: 4 bits sent, then PS2_CLK held high for TIMEOUT_CYCLES -> frame_error pulse; next full frame 29 -> Command=1.
REQ-037 SHALL cover: 3-cycle low glitches on PS2_CLK between edges -> no extra bits sampled; the byte decodes correctly.

Source files
------------

// File: rtl/ps2_command_decoder_pkg.sv
// Shared PS/2 scan-code constants, direction encodings and decoder state type.
// Also used by the grid display logic, so the encodings here are the system-wide ones.
package ps2_command_decoder_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_ENTER = 8'h5A;

   localparam logic [3:0] DIR_NONE  = 4'b0000;
   localparam logic [3:0] DIR_UP    = 4'b0001;
   localparam logic [3:0] DIR_DOWN  = 4'b0010;
   localparam logic [3:0] DIR_LEFT  = 4'b0100;
   localparam logic [3:0] DIR_RIGHT = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } scan_state_e;

   // Maps an extended scan code to its one-hot direction; DIR_NONE for non-arrows.
   function automatic logic [3:0] arrow_dir(input logic [7:0] code);
      case (code)
         SC_UP:    arrow_dir = DIR_UP;
         SC_DOWN:  arrow_dir = DIR_DOWN;
         SC_LEFT:  arrow_dir = DIR_LEFT;
         SC_RIGHT: arrow_dir = DIR_RIGHT;
         default:  arrow_dir = DIR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: input synchronizers, PS2_CLK glitch filter, 11-bit framing with
// start/parity/stop checks, and an inter-edge timeout that aborts stalled frames.
module ps2_rx #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_error
);

   localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
   localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   logic             clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
   logic             clk_filt_q, clk_filt_d;
   logic [FLT_W-1:0] filt_cnt_q, filt_cnt_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [9:0]       frame_q, frame_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [7:0]       byte_data_q, byte_data_d;
   logic             byte_valid_q, byte_valid_d;
   logic             frame_error_q, frame_error_d;
   logic             fall_edge;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      clk_filt_d    = clk_filt_q;
      filt_cnt_d    = '0;
      bit_cnt_d     = bit_cnt_q;
      frame_d       = frame_q;
      to_cnt_d      = to_cnt_q;
      byte_data_d   = byte_data_q;
      byte_valid_d  = 1'b0;
      frame_error_d = 1'b0;

      if (clk_sync_q != clk_filt_q) begin
         if (filt_cnt_q == FLT_LAST) clk_filt_d = clk_sync_q;
         else                        filt_cnt_d = filt_cnt_q + 1'b1;
      end
      fall_edge = clk_filt_q & ~clk_filt_d;

      if (fall_edge) begin
         to_cnt_d = '0;
         if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = 4'd0;
            // frame_q holds {parity, data[7:0], start}; the stop bit is the current sample.
            if (!frame_q[0] && dat_sync_q && (^frame_q[9:1])) begin
               byte_valid_d = 1'b1;
               byte_data_d  = frame_q[8:1];
            end else begin
               frame_error_d = 1'b1;
            end
         end else begin
            frame_d   = {dat_sync_q, frame_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else begin
         if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + 1'b1;
         if (bit_cnt_q != 4'd0 && to_cnt_q == TO_LAST) begin
            bit_cnt_d     = 4'd0;
            frame_error_d = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so register order never matters.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         clk_meta_q    <= 1'b0;
         clk_sync_q    <= 1'b0;
         dat_meta_q    <= 1'b0;
         dat_sync_q    <= 1'b0;
         clk_filt_q    <= 1'b1;
         filt_cnt_q    <= '0;
         bit_cnt_q     <= 4'd0;
         frame_q       <= '0;
         to_cnt_q      <= '0;
         byte_data_q   <= '0;
         byte_valid_q  <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         clk_meta_q    <= ps2_clk_i;
         clk_sync_q    <= clk_meta_q;
         dat_meta_q    <= ps2_dat_i;
         dat_sync_q    <= dat_meta_q;
         clk_filt_q    <= clk_filt_d;
         filt_cnt_q    <= filt_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         frame_q       <= frame_d;
         to_cnt_q      <= to_cnt_d;
         byte_data_q   <= byte_data_d;
         byte_valid_q  <= byte_valid_d;
         frame_error_q <= frame_error_d;
      end
   end

   assign byte_valid  = byte_valid_q;
   assign byte_data   = byte_data_q;
   assign frame_error = frame_error_q;

endmodule

// File: rtl/ps2_command_decoder.sv
// Keyboard command decoder: turns received scan codes into held arrow direction,
// Space-held command and an Enter-toggled playback enable.
module ps2_command_decoder
   import ps2_command_decoder_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       CLOCK_50,
   input  logic       Reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [3:0] Direction,
   output logic       Command,
   output logic       play_en,
   output logic       frame_error
);

   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        rx_frame_error;

   scan_state_e state_q, state_d;
   logic [3:0]  direction_q, direction_d;
   logic        command_q, command_d;
   logic        play_en_q, play_en_d;
   logic        enter_held_q, enter_held_d;

   ps2_rx #(
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk_i      (CLOCK_50),
      .rst_i      (Reset),
      .ps2_clk_i  (PS2_CLK),
      .ps2_dat_i  (PS2_DAT),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_error(rx_frame_error)
   );

   always_comb begin
      state_d      = state_q;
      direction_d  = direction_q;
      command_d    = command_q;
      play_en_d    = play_en_q;
      enter_held_d = enter_held_q;

      if (rx_frame_error) begin
         state_d = ST_IDLE;
      end else if (byte_valid) begin
         state_d = ST_IDLE;
         unique case (state_q)
            ST_IDLE: begin
               if (byte_data == SC_EXT) begin
                  state_d = ST_EXT;
               end else if (byte_data == SC_BRK) begin
                  state_d = ST_BRK;
               end else if (byte_data == SC_SPACE) begin
                  command_d = 1'b1;
               end else if (byte_data == SC_ENTER && !enter_held_q) begin
                  play_en_d    = ~play_en_q;
                  enter_held_d = 1'b1;
               end
            end
            ST_EXT: begin
               if (byte_data == SC_BRK)                   state_d     = ST_EXT_BRK;
               else if (arrow_dir(byte_data) != DIR_NONE) direction_d = arrow_dir(byte_data);
            end
            ST_BRK: begin
               if (byte_data == SC_SPACE) command_d    = 1'b0;
               if (byte_data == SC_ENTER) enter_held_d = 1'b0;
            end
            ST_EXT_BRK: begin
               // Releasing an arrow other than the one held leaves the held arrow in place.
               if (arrow_dir(byte_data) != DIR_NONE && arrow_dir(byte_data) == direction_q)
                  direction_d = DIR_NONE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         direction_q  <= DIR_NONE;
         command_q    <= 1'b0;
         play_en_q    <= 1'b0;
         enter_held_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         direction_q  <= direction_d;
         command_q    <= command_d;
         play_en_q    <= play_en_d;
         enter_held_q <= enter_held_d;
      end
   end

   assign Direction   = direction_q;
   assign Command     = command_q;
   assign play_en     = play_en_q;
   assign frame_error = rx_frame_error;

endmodule

// File: tb/tb_ps2_command_decoder.sv
// Self-checking bench for ps2_command_decoder: directed keyboard scenarios plus random
// frames, compared against a scan-sequence reference model.
module tb_ps2_command_decoder;

   localparam int FL = 8;
   localparam int TO = 400;
   localparam int HP = 12;

   logic       CLOCK_50 = 1'b0;
   logic       Reset;
   logic       PS2_CLK;
   logic       PS2_DAT;
   logic [3:0] Direction;
   logic       Command;
   logic       play_en;
   logic       frame_error;

   int vectors     = 0;
   int miscompares = 0;
   int fe_pulses   = 0;
   int fe_cycles   = 0;
   logic fe_prev   = 1'b0;

   // Reference model state.
   logic [3:0] m_dir  = 4'b0000;
   logic       m_cmd  = 1'b0;
   logic       m_play = 1'b0;
   logic       m_held = 1'b0;
   int         exp_fe = 0;
   logic [7:0] pend[$];

   ps2_command_decoder #(
      .FILTER_LEN    (FL),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .Reset      (Reset),
      .PS2_CLK    (PS2_CLK),
      .PS2_DAT    (PS2_DAT),
      .Direction  (Direction),
      .Command    (Command),
      .play_en    (play_en),
      .frame_error(frame_error)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   always @(negedge CLOCK_50) begin
      if (frame_error) fe_cycles++;
      if (frame_error && !fe_prev) fe_pulses++;
      fe_prev = frame_error;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   function automatic logic [3:0] arrow_of(input logic [7:0] b);
      case (b)
         8'h75:   return 4'b0001;
         8'h72:   return 4'b0010;
         8'h6B:   return 4'b0100;
         8'h74:   return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   // Model: prefixes accumulate in a queue; the first non-prefix byte completes the
   // key event, whose kind is read off the prefixes collected so far.
   task automatic model_byte(input logic [7:0] b);
      bit ext, brk;
      if (b == 8'hE0 && pend.size() == 0) begin
         pend.push_back(b);
      end else if (b == 8'hF0 && (pend.size() == 0 || (pend.size() == 1 && pend[0] == 8'hE0))) begin
         pend.push_back(b);
      end else begin
         ext = (pend.size() > 0 && pend[0] == 8'hE0);
         brk = (pend.size() > 0 && pend[pend.size()-1] == 8'hF0);
         if (!ext && !brk) begin
            if (b == 8'h29) m_cmd = 1'b1;
            if (b == 8'h5A && !m_held) begin
               m_play = ~m_play;
               m_held = 1'b1;
            end
         end else if (!ext && brk) begin
            if (b == 8'h29) m_cmd  = 1'b0;
            if (b == 8'h5A) m_held = 1'b0;
         end else if (ext && !brk) begin
            if (arrow_of(b) != 4'b0000) m_dir = arrow_of(b);
         end else begin
            if (arrow_of(b) != 4'b0000 && arrow_of(b) == m_dir) m_dir = 4'b0000;
         end
         pend.delete();
      end
   endtask

   task automatic model_frame_error();
      exp_fe++;
      pend.delete();
   endtask

   task automatic model_reset();
      m_dir  = 4'b0000;
      m_cmd  = 1'b0;
      m_play = 1'b0;
      m_held = 1'b0;
      pend.delete();
   endtask

   task automatic check_state(input string tag);
      check({tag, "/dir"}, Direction, m_dir);
      check({tag, "/cmd"}, Command, m_cmd);
      check({tag, "/play"}, play_en, m_play);
      check({tag, "/fe_pulses"}, fe_pulses, exp_fe);
      check({tag, "/fe_width"}, fe_cycles, exp_fe);
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      PS2_DAT = b;
      if (glitch) begin
         wait_clk(4);
         PS2_CLK = 1'b0;
         wait_clk(3);
         PS2_CLK = 1'b1;
         wait_clk(HP - 7);
      end else begin
         wait_clk(HP);
      end
      PS2_CLK = 1'b0;
      wait_clk(2 * HP);
      PS2_CLK = 1'b1;
      wait_clk(HP);
   endtask

   // Full frame; optional bad parity, clock glitches, and output-latency check on the stop bit.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch, input bit lat);
      logic [3:0] old_dir;
      int seen;
      old_dir = m_dir;
      seen = 0;
      send_bit(1'b0, glitch);
      for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
      send_bit(~(^b) ^ bad_par, glitch);
      if (bad_par) model_frame_error();
      else         model_byte(b);
      PS2_DAT = 1'b1;
      wait_clk(HP);
      PS2_CLK = 1'b0;
      for (int i = 0; i < 2 * HP; i++) begin
         @(negedge CLOCK_50);
         if (lat && seen == 1) begin
            check("latency/after_byte_valid", Direction, m_dir);
            seen = 2;
         end else if (lat && seen == 0 && dut.u_rx.byte_valid) begin
            check("latency/at_byte_valid", Direction, old_dir);
            seen = 1;
         end
      end
      if (lat) check("latency/byte_valid_seen", seen, 2);
      PS2_CLK = 1'b1;
      wait_clk(3 * HP);
      check_state($sformatf("frame_%02h", b));
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits);
      logic [10:0] bits;
      bits = {1'b1, ~(^b), b, 1'b0};
      for (int i = 0; i < nbits; i++) send_bit(bits[i], 1'b0);
   endtask

   initial begin
      logic [7:0] codes [8];
      logic [7:0] b;
      codes = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h5A};

      PS2_CLK = 1'b1;
      PS2_DAT = 1'b1;
      Reset   = 1'b1;
      wait_clk(5);
      check("reset/dir", Direction, 4'b0000);
      check("reset/cmd", Command, 1'b0);
      check("reset/play", play_en, 1'b0);
      check("reset/fe", frame_error, 1'b0);
      Reset = 1'b0;
      wait_clk(20);

      // Arrow press with latency check, then release.
      send_frame(8'hE0, 0, 0, 0);
      send_frame(8'h75, 0, 0, 1);
      check("up/dir", Direction, 4'b0001);
      send_frame(8'hE0, 0, 0, 0);
      send_frame(8'hF0, 0, 0, 0);
      send_frame(8'h75, 0, 0, 0);
      check("up_release/dir", Direction, 4'b0000);

      // Last arrow wins; releasing a non-held arrow changes nothing.
      send_frame(8'hE0, 0, 0, 0);
      send_frame(8'h6B, 0, 0, 0);
      check("left/dir", Direction, 4'b0100);
      send_frame(8'hE0, 0, 0, 0);
      send_frame(8'h74, 0, 0, 1);
      check("right/dir", Direction, 4'b1000);
      send_frame(8'hE0, 0, 0, 0);
      send_frame(8'hF0, 0, 0, 0);
      send_frame(8'h6B, 0, 0, 0);
      check("left_release/dir", Direction, 4'b1000);

      // Enter toggles once per press; typematic repeat suppressed until break.
      send_frame(8'h5A, 0, 0, 0);
      check("enter1/play", play_en, 1'b1);
      send_frame(8'h5A, 0, 0, 0);
      check("enter_repeat/play", play_en, 1'b1);
      send_frame(8'hF0, 0, 0, 0);
      send_frame(8'h5A, 0, 0, 0);
      check("enter_break/play", play_en, 1'b1);
      send_frame(8'h5A, 0, 0, 0);
      check("enter2/play", play_en, 1'b0);

      // Bad parity is discarded; the following good Space is accepted.
      send_frame(8'h29, 1, 0, 0);
      check("bad_parity/cmd", Command, 1'b0);
      send_frame(8'h29, 0, 0, 0);
      check("space/cmd", Command, 1'b1);
      send_frame(8'h29, 0, 0, 0);
      check("space_repeat/cmd", Command, 1'b1);
      send_frame(8'hF0, 0, 0, 0);
      send_frame(8'h29, 0, 0, 0);
      check("space_release/cmd", Command, 1'b0);

      // Stalled partial frame times out.
      send_partial(8'h29, 4);
      wait_clk(TO + 50);
      model_frame_error();
      check_state("timeout");
      send_frame(8'h29, 0, 0, 0);
      check("after_timeout/cmd", Command, 1'b1);
      send_frame(8'hF0, 0, 0, 0);
      send_frame(8'h29, 0, 0, 0);

      // Short clock glitches between edges are filtered out.
      send_frame(8'h29, 0, 1, 0);
      check("glitch_space/cmd", Command, 1'b1);
      send_frame(8'hE0, 0, 1, 0);
      send_frame(8'h72, 0, 1, 0);
      check("glitch_down/dir", Direction, 4'b0010);

      // Reset mid-frame: clean abort, no frame_error, reception resumes.
      send_partial(8'h5A, 5);
      Reset = 1'b1;
      wait_clk(3);
      model_reset();
      check_state("mid_reset");
      Reset = 1'b0;
      wait_clk(TO + 50);
      check_state("after_reset_idle");
      send_frame(8'h5A, 0, 0, 0);
      check("after_reset/play", play_en, 1'b1);

      // Random scan-code traffic with occasional parity errors and glitches.
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) < 8) b = codes[$urandom_range(0, 7)];
         else                          b = 8'($urandom_range(0, 255));
         send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
